chunked_add_sub: RTL and testbench



---
 rtl/chunked_add_sub_pkg.sv | 22 ++
 rtl/chunked_add_sub_chunk_adder.sv | 40 ++++
 rtl/chunked_add_sub.sv | 158 +++++++++++++++
 tb/tb_chunked_add_sub.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/chunked_add_sub_pkg.sv
// Shared definitions for chunked_add_sub: FSM encoding and parameter-derived sizes.
package chunked_add_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Index width for n chunks; a single chunk still needs one bit of counter.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunked_add_sub_chunk_adder.sv
// CHUNK-bit combinational ripple-carry slice built from full_adder cells.
// Also exposes the carry into the slice MSB so the top can form signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one shared slice.
// Optional Zero flag output when CHUNKED_ADD_SUB_ZERO_FLAG_EN is defined.
module chunked_add_sub
  import chunked_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
  ,
  output logic             Zero
`endif
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = clog2_min1(NCHUNK);
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("chunked_add_sub: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_chunk, b_chunk, slice_sum;
  logic             slice_cout, slice_cmsb;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = Start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Ready = (state_q != S_RUN);
    Done  = (state_q == S_DONE);
  end

  assign accept = Start & Ready;
  assign last   = (idx_q == LAST);

  always_comb begin
    a_chunk = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk = b_q[idx_q*CHUNK +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    if (accept) begin
      // Subtract is A + ~B + ~borrow; results stay visible until overwritten.
      a_d     = A;
      b_d     = Sub ? ~B : B;
      carry_d = Cin ^ Sub;
      idx_d   = '0;
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
      zero_d  = 1'b0;
      if (state_q == S_RUN) zero_d = zero_q;
`endif
    end else if (state_q == S_RUN) begin
      sum_d[idx_q*CHUNK +: CHUNK] = slice_sum;
      carry_d = slice_cout;
      idx_d   = last ? '0 : idx_q + 1'b1;
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
      zero_d  = ((idx_q == '0) ? 1'b1 : zero_q) & (slice_sum == '0);
`endif
      if (last) begin
        cout_d = slice_cout;
        ovf_d  = slice_cmsb ^ slice_cout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
  assign Zero     = zero_q;
`endif

endmodule

// File: tb/tb_chunked_add_sub.sv
// Scoreboard bench for chunked_add_sub at WIDTH=16 with CHUNK = 4, 1 and 16.
module tb_chunked_add_sub;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [3];
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready [3];
  logic        done  [3];
  logic [15:0] sum_o [3];
  logic        cout_o[3];
  logic        ovf_o [3];
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
  logic        zero_o[3];
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  int   nch[3] = '{4, 16, 1};
  exp_t exp_q[3][$];

  always #5 clk = ~clk;

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .Start(start[0]), .Sub(sub), .A(a), .B(b), .Cin(cin),
    .Ready(ready[0]), .Done(done[0]), .Sum(sum_o[0]), .Cout(cout_o[0]), .Overflow(ovf_o[0])
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
    , .Zero(zero_o[0])
`endif
  );

  chunked_add_sub #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .Start(start[1]), .Sub(sub), .A(a), .B(b), .Cin(cin),
    .Ready(ready[1]), .Done(done[1]), .Sum(sum_o[1]), .Cout(cout_o[1]), .Overflow(ovf_o[1])
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
    , .Zero(zero_o[1])
`endif
  );

  chunked_add_sub #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .Start(start[2]), .Sub(sub), .A(a), .B(b), .Cin(cin),
    .Ready(ready[2]), .Done(done[2]), .Sum(sum_o[2]), .Cout(cout_o[2]), .Overflow(ovf_o[2])
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
    , .Zero(zero_o[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic in plain integers, independent of the chunked datapath.
  function automatic exp_t model(input logic [15:0] fa, input logic [15:0] fb,
                                 input logic fsub, input logic fcin);
    exp_t e;
    int   r, sr;
    if (!fsub) begin
      r      = int'(fa) + int'(fb) + int'(fcin);
      sr     = int'($signed(fa)) + int'($signed(fb)) + int'(fcin);
      e.cout = (r > 65535);
    end else begin
      r      = int'(fa) - int'(fb) - int'(fcin);
      sr     = int'($signed(fa)) - int'($signed(fb)) - int'(fcin);
      e.cout = (r >= 0);
    end
    e.sum  = r[15:0];
    e.ovf  = (sr > 32767) || (sr < -32768);
    e.zero = (e.sum == 16'h0000);
    return e;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done[k]) begin
        if (exp_q[k].size() == 0) chk($sformatf("unexp_done%0d", k), 1, 0);
        else begin
          exp_t e;
          e = exp_q[k].pop_front();
          chk($sformatf("sum%0d", k),  32'(sum_o[k]), 32'(e.sum));
          chk($sformatf("cout%0d", k), 32'(cout_o[k]), 32'(e.cout));
          chk($sformatf("ovf%0d", k),  32'(ovf_o[k]), 32'(e.ovf));
`ifdef CHUNKED_ADD_SUB_ZERO_FLAG_EN
          chk($sformatf("zero%0d", k), 32'(zero_o[k]), 32'(e.zero));
`endif
        end
      end
    end
  end

  task automatic drive(input int k, input logic [15:0] da, input logic [15:0] db,
                       input logic dsub, input logic dcin, input bit push);
    a = da; b = db; sub = dsub; cin = dcin; start[k] = 1'b1;
    if (push) exp_q[k].push_back(model(da, db, dsub, dcin));
  endtask

  task automatic wait_done(input int k, output int lat, output int rlow);
    lat = 0; rlow = 0;
    do begin
      @(negedge clk);
      start[k] = 1'b0;
      lat++;
      if (!ready[k]) rlow++;
    end while (!done[k] && lat < 64);
    if (!done[k]) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int k, input logic [15:0] da, input logic [15:0] db,
                        input logic dsub, input logic dcin);
    int lat, rlow;
    @(negedge clk);
    chk("rdy_at_start", 32'(ready[k]), 1);
    drive(k, da, db, dsub, dcin, 1'b1);
    wait_done(k, lat, rlow);
    chk($sformatf("latency%0d", k), lat, nch[k] + 1);
    chk($sformatf("ready_low%0d", k), rlow, nch[k]);
  endtask

  initial begin
    int lat, rlow, seen;
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(ready[k]), 1);
      chk("rst_done",  32'(done[k]), 0);
      chk("rst_sum",   32'(sum_o[k]), 0);
      chk("rst_cout",  32'(cout_o[k]), 0);
      chk("rst_ovf",   32'(ovf_o[k]), 0);
    end

    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    chk("sum_5555", 32'(sum_o[0]), 32'h5555);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("sum_wrap", 32'(sum_o[0]), 32'h0000);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("ovf_add", 32'(ovf_o[0]), 1);
    run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0);
    chk("sum_fffe", 32'(sum_o[0]), 32'hFFFE);
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0);
    chk("sum_7fff", 32'(sum_o[0]), 32'h7FFF);
    run_op(0, 16'h1000, 16'h0FFF, 1'b1, 1'b1);

    // Start held through RUN with changing operands, then accepted in DONE.
    @(negedge clk);
    drive(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("run_busy", 32'(ready[0]), 0);
      chk("run_nodone", 32'(done[0]), 0);
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    end
    @(negedge clk);
    chk("b2b_done", 32'(done[0]), 1);
    drive(0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b1);
    wait_done(0, lat, rlow);
    chk("b2b_latency", lat, 5);

    // Reset on the second RUN cycle aborts the op without a Done.
    @(negedge clk);
    drive(0, 16'h3333, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(ready[0]), 1);
    chk("abort_sum",   32'(sum_o[0]), 0);
    chk("abort_done",  32'(done[0]), 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op(0, 16'h8000, 16'h8000, 1'b0, 1'b1);

    for (int k = 0; k < 3; k++) begin
      run_op(k, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
      run_op(k, 16'h0000, 16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++)
        run_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("queue_empty", exp_q[k].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
